command_receiver: RTL and testbench

//  Host->FPGA counterpart of the result path: a UART (8N1) receiver plus a frame parser that loads tap words into per-module config registers.

---
 rtl/command_receiver_pkg.sv | 30 +++
 rtl/command_receiver_rs232_rx_byte.sv | 108 ++++++++++
 rtl/command_receiver.sv | 157 +++++++++++++++
 tb/tb_command_receiver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/command_receiver_pkg.sv
// Shared frame constants and state encodings for the host->FPGA command path.
// The result path uses the same header and byte order, so both directions live here.
package command_receiver_pkg;

    localparam int         BYTE_W     = 8;
    localparam logic [7:0] FRAME_HDR  = 8'hFF;

    // Result-path framing: same header, module index next, tap byte 0 first.
    localparam logic [7:0] RESULT_HDR     = 8'hFF;
    localparam int         RESULT_IDX_POS = 1;

    typedef enum logic [3:0] {
        HUNT   = 4'b0001,
        INDEX  = 4'b0010,
        TAPS   = 4'b0100,
        COMMIT = 4'b1000
    } parser_state_t;

    typedef enum logic [3:0] {
        RX_IDLE  = 4'b0001,
        RX_START = 4'b0010,
        RX_DATA  = 4'b0100,
        RX_STOP  = 4'b1000
    } rx_state_t;

    function automatic logic is_header(input logic [7:0] b);
        return (b == FRAME_HDR);
    endfunction

endpackage

// File: rtl/command_receiver_rs232_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// mid-bit sampling LSB first, stop-bit framing check.
module rs232_rx_byte
    import command_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] dout,
    output logic       byte_valid,
    output logic       rx_ferr
);

    localparam int                   BIT_CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t              r_state;
    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic [7:0]             r_dout;
    logic                   r_byte_valid;
    logic                   r_rx_ferr;

    // Synchronizer, edge detector and bit-sampling state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RX_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_bit_cnt    <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_dout       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_rx_meta    <= RX;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_rx_ferr    <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_bit_cnt <= '0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_state <= RX_START;
                    end else begin
                        r_state <= RX_IDLE;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (r_bit_cnt == HALF_LAST) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
                        r_state   <= RX_IDLE;
                        if (r_rx_sync) begin
                            r_dout       <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= RX_IDLE;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign byte_valid = r_byte_valid;
    assign rx_ferr    = r_rx_ferr;

endmodule

// File: rtl/command_receiver.sv
// Command frame parser: FF header, module index, NUM_OF_TAPS tap bytes (byte 0 -> bits [7:0]),
// committed into the per-module config word with a one-cycle load pulse.
module command_receiver
    import command_receiver_pkg::*;
#(
    parameter int NUM_OF_TAPS    = 5,
    parameter int NUM_OF_MODULES = 20,
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      RX,
    output logic [NUM_OF_MODULES*NUM_OF_TAPS*8-1:0]   cfg_buf,
    output logic [NUM_OF_MODULES-1:0]                 load,
    output logic                                      frame_err,
    output logic                                      busy
);

    localparam int WORD_W      = NUM_OF_TAPS * BYTE_W;
    localparam int GAP_LIMIT_I = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W       = $clog2(GAP_LIMIT_I) + 1;
    localparam int CNT_W       = $clog2(NUM_OF_TAPS + 1);

    localparam logic [GAP_W-1:0]          GAP_LIMIT = GAP_W'(GAP_LIMIT_I);
    localparam logic [CNT_W-1:0]          TAP_LAST  = CNT_W'(NUM_OF_TAPS - 1);
    localparam logic [7:0]                NUM_MOD   = 8'(NUM_OF_MODULES);
    localparam logic [NUM_OF_MODULES-1:0] LOAD_LSB  = NUM_OF_MODULES'(1);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_rx_ferr;
    logic       w_abort;

    parser_state_t                              r_state;
    logic [7:0]                                 r_idx;
    logic [CNT_W-1:0]                           r_cnt;
    logic [WORD_W-1:0]                          r_shadow;
    logic [GAP_W-1:0]                           r_gap;
    logic [NUM_OF_MODULES*WORD_W-1:0]           r_cfg_buf;
    logic [NUM_OF_MODULES-1:0]                  r_load;
    logic                                       r_frame_err;
    logic                                       r_busy;

    rs232_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .dout       (w_byte),
        .byte_valid (w_byte_valid),
        .rx_ferr    (w_rx_ferr)
    );

    // Mid-frame abort: a received byte always beats a framing error or gap expiry.
    always_comb begin
        w_abort = 1'b0;
        if ((r_state == INDEX || r_state == TAPS) && !w_byte_valid) begin
            w_abort = w_rx_ferr || (r_gap == GAP_LIMIT);
        end else begin
            w_abort = 1'b0;
        end
    end

    // Frame parser, gap timer and committed config words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_idx       <= 8'h00;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_gap       <= '0;
            r_cfg_buf   <= '0;
            r_load      <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_load      <= '0;
            r_frame_err <= 1'b0;
            if (w_abort) begin
                r_frame_err <= 1'b1;
                r_busy      <= 1'b0;
                r_shadow    <= '0;
                r_gap       <= '0;
                r_state     <= HUNT;
            end else begin
                case (r_state)
                    HUNT: begin
                        r_gap <= '0;
                        if (w_byte_valid && is_header(w_byte)) begin
                            r_busy  <= 1'b1;
                            r_state <= INDEX;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                    INDEX: begin
                        // The index byte is never reinterpreted as a header, even 0xFF.
                        if (w_byte_valid) begin
                            r_gap <= '0;
                            if (w_byte < NUM_MOD) begin
                                r_idx    <= w_byte;
                                r_shadow <= '0;
                                r_cnt    <= '0;
                                r_state  <= TAPS;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= HUNT;
                            end
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    TAPS: begin
                        if (w_byte_valid) begin
                            r_gap <= '0;
                            r_shadow[r_cnt*BYTE_W +: BYTE_W] <= w_byte;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == TAP_LAST) begin
                                r_state <= COMMIT;
                            end else begin
                                r_state <= TAPS;
                            end
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    COMMIT: begin
                        // A zero first tap is never sent by the host, so it marks corruption.
                        if (r_shadow[7:0] == 8'h00) begin
                            r_frame_err <= 1'b1;
                        end else begin
                            r_cfg_buf[r_idx*WORD_W +: WORD_W] <= r_shadow;
                            r_load <= LOAD_LSB << r_idx;
                        end
                        r_gap   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= HUNT;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_gap   <= '0;
                        r_state <= HUNT;
                    end
                endcase
            end
        end
    end

    assign cfg_buf   = r_cfg_buf;
    assign load      = r_load;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_command_receiver.sv
// Directed serial-frame bench for command_receiver with CLKS_PER_BIT=16.
module tb_command_receiver;

    localparam int CPB = 16;
    localparam int NT  = 5;
    localparam int NM  = 20;
    localparam int W   = NT * 8;
    localparam int CW  = NM * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RX  = 1'b1;
    logic [CW-1:0] cfg_buf;
    logic [NM-1:0] load;
    logic          frame_err;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    int            load_cnt  = 0;
    int            err_cnt   = 0;
    int            bv_cnt    = 0;
    int            cyc       = 0;
    int            bv_cyc    = 0;
    int            ld_lat    = 0;
    int            viol      = 0;
    logic [NM-1:0] last_load = '0;

    logic [CW-1:0] exp_cfg = '0;
    int l0, e0, b0, wait_n;

    command_receiver #(
        .NUM_OF_TAPS    (NT),
        .NUM_OF_MODULES (NM),
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_BITS   (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .cfg_buf   (cfg_buf),
        .load      (load),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Event recorder: pulse counts, last load vector, load latency, exclusivity violations.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dut.w_byte_valid) begin
            bv_cnt <= bv_cnt + 1;
            bv_cyc <= cyc;
        end
        if (load != '0) begin
            load_cnt  <= load_cnt + 1;
            last_load <= load;
            ld_lat    <= cyc - bv_cyc;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (((load & (load - 1'b1)) != '0) || (frame_err && load != '0)) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        RX = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_seq(input logic [63:0] seq, input int n);
        for (int k = 0; k < n; k++) send_byte(seq[8*(n-1-k) +: 8], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_cfg", cfg_buf, '0);
        chk("rst_load", load, '0);
        chk("rst_ferr", frame_err, '0);
        chk("rst_busy", busy, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: normal frame to module 3
        l0 = load_cnt; e0 = err_cnt;
        send_seq(64'hFF_03_11_22_33_44_55, 7);
        exp_cfg[3*W +: W] = 40'h5544332211;
        chk("t1_load_pulses", load_cnt - l0, 1);
        chk("t1_load_vec", last_load, 20'h00008);
        chk("t1_word3", cfg_buf[3*W +: W], 40'h5544332211);
        chk("t1_cfg", cfg_buf, exp_cfg);
        chk("t1_no_err", err_cnt - e0, 0);
        chk("t1_latency", ld_lat, 2);
        chk("t1_busy", busy, 0);

        // 2: out-of-range index
        l0 = load_cnt; e0 = err_cnt;
        send_seq(64'hFF_14, 2);
        chk("t2_err_after_idx", err_cnt - e0, 1);
        chk("t2_busy", busy, 0);
        send_seq(64'h01_02_03_04_05, 5);
        chk("t2_err_total", err_cnt - e0, 1);
        chk("t2_no_load", load_cnt - l0, 0);
        chk("t2_cfg", cfg_buf, exp_cfg);

        // 3: zero first tap rejected, then 0xFF taps accepted as data
        l0 = load_cnt; e0 = err_cnt;
        send_seq(64'hFF_00_00_AA_BB_CC_DD, 7);
        chk("t3_zero_err", err_cnt - e0, 1);
        chk("t3_zero_noload", load_cnt - l0, 0);
        chk("t3_zero_cfg", cfg_buf, exp_cfg);
        send_seq(64'hFF_00_FF_FF_FF_FF_FF, 7);
        exp_cfg[0 +: W] = 40'hFFFFFFFFFF;
        chk("t3_ff_word0", cfg_buf[0 +: W], 40'hFFFFFFFFFF);
        chk("t3_ff_load_vec", last_load, 20'h00001);
        chk("t3_ff_cfg", cfg_buf, exp_cfg);
        chk("t3_ff_err", err_cnt - e0, 1);

        // 4: inter-byte timeout, then recovery
        e0 = err_cnt; l0 = load_cnt;
        send_seq(64'hFF_05_01_02, 4);
        chk("t4_busy_mid", busy, 1);
        wait_n = 0;
        while (wait_n < 600 && err_cnt == e0) begin
            @(negedge clk);
            wait_n++;
        end
        chk("t4_timeout_err", err_cnt - e0, 1);
        chk("t4_timeout_window", (wait_n >= 280 && wait_n <= 340), 1);
        chk("t4_busy_after", busy, 0);
        send_seq(64'hFF_05_A1_B2_C3_D4_E5, 7);
        exp_cfg[5*W +: W] = 40'hE5D4C3B2A1;
        chk("t4_word5", cfg_buf[5*W +: W], 40'hE5D4C3B2A1);
        chk("t4_load_vec", last_load, 20'h00020);
        chk("t4_load_pulses", load_cnt - l0, 1);

        // 5: stop bit low on 2nd tap, then idle glitch
        e0 = err_cnt; l0 = load_cnt;
        send_seq(64'hFF_07_10, 3);
        send_byte(8'h20, 1'b0);
        repeat (4) @(negedge clk);
        chk("t5_ferr_err", err_cnt - e0, 1);
        chk("t5_ferr_busy", busy, 0);
        send_seq(64'h30_40_50, 3);
        chk("t5_no_load", load_cnt - l0, 0);
        chk("t5_cfg", cfg_buf, exp_cfg);
        b0 = bv_cnt;
        RX = 1'b0;
        repeat (5) @(negedge clk);
        RX = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        chk("t5_glitch_nobyte", bv_cnt - b0, 0);
        chk("t5_glitch_busy", busy, 0);

        // 6: reset in TAPS, then clean frame
        send_seq(64'hFF_09_01_02, 4);
        chk("t6_busy_taps", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_cfg", cfg_buf, '0);
        chk("t6_rst_load", load, '0);
        chk("t6_rst_ferr", frame_err, '0);
        chk("t6_rst_busy", busy, '0);
        rst = 1'b0;
        exp_cfg = '0;
        repeat (4) @(negedge clk);
        l0 = load_cnt;
        send_seq(64'hFF_09_5A_6B_7C_8D_9E, 7);
        exp_cfg[9*W +: W] = 40'h9E8D7C6B5A;
        chk("t6_cfg", cfg_buf, exp_cfg);
        chk("t6_load_vec", last_load, 20'h00200);
        chk("t6_load_pulses", load_cnt - l0, 1);

        chk("exclusivity", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
